// File: rtl/sd_card_router_if.sv
// sd_card_router_if: bundles the SD routing signals between the core SPI master,
// the mount-event source, the physical card pins and the virtual card instances.
//   slave  : router side (sd_card_router)
//   master : environment side (core, sd_card instances, pins)
//   img_mounted/img_nz        mount pulses and non-zero flags per slot
//   spi_sck/mosi/ss_n/miso    core SPI master
//   sd_sck/mosi/cs_n/miso     physical card
//   vsd_ss_n/vsd_miso         virtual cards
//   active_slot/mounted       selection and mount state
//   reset_img/act             image-change reset and activity strobes
interface sd_card_router_if #(
    parameter int unsigned SLOTS = 2
);
    localparam int unsigned W = $clog2(SLOTS + 1);

    logic [SLOTS-1:0] img_mounted;
    logic [SLOTS-1:0] img_nz;
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_ss_n;
    logic             spi_miso;
    logic             sd_miso;
    logic             sd_sck;
    logic             sd_mosi;
    logic             sd_cs_n;
    logic [SLOTS-1:0] vsd_miso;
    logic [SLOTS-1:0] vsd_ss_n;
    logic [W-1:0]     active_slot;
    logic [SLOTS-1:0] mounted;
    logic             reset_img;
    logic [SLOTS:0]   act;

    modport slave (
        input  img_mounted, img_nz, spi_sck, spi_mosi, spi_ss_n, sd_miso, vsd_miso,
        output spi_miso, sd_sck, sd_mosi, sd_cs_n, vsd_ss_n, active_slot, mounted,
               reset_img, act
    );

    modport master (
        output img_mounted, img_nz, spi_sck, spi_mosi, spi_ss_n, sd_miso, vsd_miso,
        input  spi_miso, sd_sck, sd_mosi, sd_cs_n, vsd_ss_n, active_slot, mounted,
               reset_img, act
    );
endinterface

// File: rtl/sd_card_router.sv
// sd_card_router: steers the core SPI master to the physical SD card or one of
// SLOTS virtual images, tracks per-slot mount state, raises a retriggerable
// image-change reset pulse and per-channel activity strobes.
//   clk_sys : system clock
//   reset   : asynchronous active-high reset
//   bus     : sd_card_router_if.slave (mount events, SPI, card pins, status)
module sd_card_router #(
    parameter int unsigned SLOTS      = 2,
    parameter int unsigned RST_CYCLES = 10000000,
    parameter int unsigned ACT_CYCLES = 1000000,
    parameter int unsigned RST_ON_ANY = 1
) (
    input  logic            clk_sys,
    input  logic            reset,
    sd_card_router_if.slave bus
);
    localparam int unsigned W  = $clog2(SLOTS + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned AW = $clog2(ACT_CYCLES + 1);
    localparam int unsigned CH = SLOTS + 1;

    logic [W-1:0]     active_q;
    logic [W-1:0]     active_nxt;
    logic [W-1:0]     fallback_c;
    logic [W-1:0]     lowest_set_c;
    logic [SLOTS-1:0] set_mask_c;
    logic [SLOTS-1:0] mounted_q;
    logic [SLOTS-1:0] mounted_nxt;
    logic             qualify_c;
    logic [RW-1:0]    rst_cnt_q;
    logic [RW-1:0]    rst_cnt_nxt;
    logic             reset_img_q;
    logic             mosi_q;
    logic             mosi_qq;
    logic             miso_q;
    logic             miso_qq;
    logic             toggle_c;
    logic [AW-1:0]    tmr_q   [CH];
    logic [AW-1:0]    tmr_nxt [CH];
    logic [CH-1:0]    act_q;
    logic [CH-1:0]    act_nxt;
    logic             spi_miso_c;
    logic             sd_cs_c;
    logic [SLOTS-1:0] vsd_ss_c;

    // Mount bookkeeping, active-slot selection and reset-pulse counter.
    always_comb begin
        set_mask_c   = bus.img_mounted & bus.img_nz;
        mounted_nxt  = (mounted_q & ~bus.img_mounted) | set_mask_c;
        fallback_c   = '0;
        lowest_set_c = '0;
        // Descending scan so the lowest index wins.
        for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
            if (mounted_nxt[i]) fallback_c = W'(i + 1);
            if (set_mask_c[i])  lowest_set_c = W'(i + 1);
        end
        active_nxt = active_q;
        if (|set_mask_c) begin
            active_nxt = lowest_set_c;
        end else begin
            // Only an unmount of the active slot moves the selection.
            for (int i = 0; i < int'(SLOTS); i++) begin
                if (bus.img_mounted[i] && (active_q == W'(i + 1))) active_nxt = fallback_c;
            end
        end
        qualify_c = (RST_ON_ANY != 0) ? (|bus.img_mounted) : (active_nxt != active_q);
        if (qualify_c) begin
            rst_cnt_nxt = RW'(RST_CYCLES);
        end else if (rst_cnt_q != '0) begin
            rst_cnt_nxt = rst_cnt_q - RW'(1);
        end else begin
            rst_cnt_nxt = '0;
        end
    end

    // SPI steering; follows the registered selection with no extra latency.
    always_comb begin
        sd_cs_c    = bus.spi_ss_n | (active_q != '0);
        spi_miso_c = 1'b1;
        if (active_q == '0) spi_miso_c = bus.sd_miso;
        for (int k = 0; k < int'(SLOTS); k++) begin
            vsd_ss_c[k] = bus.spi_ss_n | (active_q != W'(k + 1));
            if (active_q == W'(k + 1)) spi_miso_c = bus.vsd_miso[k];
        end
    end

    // Activity timers: a data toggle restarts the timer of the selected channel.
    always_comb begin
        toggle_c = (mosi_q ^ mosi_qq) | (miso_q ^ miso_qq);
        for (int c = 0; c < int'(CH); c++) begin
            if (toggle_c && (active_q == W'(c))) begin
                tmr_nxt[c] = '0;
            end else if (tmr_q[c] < AW'(ACT_CYCLES)) begin
                tmr_nxt[c] = tmr_q[c] + AW'(1);
            end else begin
                tmr_nxt[c] = tmr_q[c];
            end
            act_nxt[c] = tmr_nxt[c] < AW'(ACT_CYCLES);
        end
    end

    // State registers; SPI edge samplers idle high.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            active_q    <= '0;
            mounted_q   <= '0;
            rst_cnt_q   <= '0;
            reset_img_q <= 1'b0;
            mosi_q      <= 1'b1;
            mosi_qq     <= 1'b1;
            miso_q      <= 1'b1;
            miso_qq     <= 1'b1;
            act_q       <= '0;
            for (int c = 0; c < int'(CH); c++) tmr_q[c] <= AW'(ACT_CYCLES);
        end else begin
            active_q    <= active_nxt;
            mounted_q   <= mounted_nxt;
            rst_cnt_q   <= rst_cnt_nxt;
            reset_img_q <= rst_cnt_nxt != '0;
            mosi_q      <= bus.spi_mosi;
            mosi_qq     <= mosi_q;
            miso_q      <= spi_miso_c;
            miso_qq     <= miso_q;
            act_q       <= act_nxt;
            for (int c = 0; c < int'(CH); c++) tmr_q[c] <= tmr_nxt[c];
        end
    end

    assign bus.active_slot = active_q;
    assign bus.mounted     = mounted_q;
    assign bus.reset_img   = reset_img_q;
    assign bus.act         = act_q;
    assign bus.sd_cs_n     = sd_cs_c;
    assign bus.sd_sck      = bus.spi_sck & ~sd_cs_c;
    assign bus.sd_mosi     = bus.spi_mosi & ~sd_cs_c;
    assign bus.vsd_ss_n    = vsd_ss_c;
    assign bus.spi_miso    = spi_miso_c;
endmodule

// File: tb/tb_sd_card_router.sv
// tb_sd_card_router: directed scenarios followed by random traffic, checked
// against an event-time reference model. Two routers share the stimulus: one
// resets on any mount event, the other only when the selection changes.
module tb_sd_card_router;
    localparam int SLOTS = 2;
    localparam int RST_N = 16;
    localparam int ACT_N = 8;
    localparam int NEVER = -1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] img_mounted;
    logic [1:0] img_nz;
    logic [1:0] vsd_miso;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       sd_miso;

    always #5 clk = ~clk;

    sd_card_router_if #(.SLOTS(SLOTS)) if_any ();
    sd_card_router_if #(.SLOTS(SLOTS)) if_chg ();

    assign if_any.img_mounted = img_mounted;
    assign if_any.img_nz      = img_nz;
    assign if_any.spi_sck     = spi_sck;
    assign if_any.spi_mosi    = spi_mosi;
    assign if_any.spi_ss_n    = spi_ss_n;
    assign if_any.sd_miso     = sd_miso;
    assign if_any.vsd_miso    = vsd_miso;
    assign if_chg.img_mounted = img_mounted;
    assign if_chg.img_nz      = img_nz;
    assign if_chg.spi_sck     = spi_sck;
    assign if_chg.spi_mosi    = spi_mosi;
    assign if_chg.spi_ss_n    = spi_ss_n;
    assign if_chg.sd_miso     = sd_miso;
    assign if_chg.vsd_miso    = vsd_miso;

    sd_card_router #(.SLOTS(SLOTS), .RST_CYCLES(RST_N), .ACT_CYCLES(ACT_N), .RST_ON_ANY(1))
        dut_any (.clk_sys(clk), .reset(rst), .bus(if_any));
    sd_card_router #(.SLOTS(SLOTS), .RST_CYCLES(RST_N), .ACT_CYCLES(ACT_N), .RST_ON_ANY(0))
        dut_chg (.clk_sys(clk), .reset(rst), .bus(if_chg));

    int total = 0;
    int bad   = 0;

    // Reference model: edge count plus the edge at which each thing last happened.
    int   cyc = 0;
    bit [1:0] m_mounted;
    int   m_active;
    int   last_evt_any;
    int   last_evt_chg;
    int   last_clear [3];
    bit   pend;
    int   pend_ch;
    bit   p_mosi;
    bit   p_miso;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit route_miso();
        if (m_active == 0) return sd_miso;
        if (m_active == 1) return vsd_miso[0];
        return vsd_miso[1];
    endfunction

    task automatic model_reset();
        m_mounted    = '0;
        m_active     = 0;
        last_evt_any = NEVER;
        last_evt_chg = NEVER;
        for (int c = 0; c < 3; c++) last_clear[c] = NEVER;
        pend    = 1'b0;
        pend_ch = 0;
        p_mosi  = 1'b1;
        p_miso  = 1'b1;
    endtask

    task automatic model_edge();
        bit [1:0] new_m;
        bit       tog;
        bit       found;
        bit       miso_now;
        int       old;
        int       na;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        // A toggle seen at the previous edge restarts its channel now.
        if (pend) last_clear[pend_ch] = cyc;
        miso_now = route_miso();
        tog      = (spi_mosi != p_mosi) || (miso_now != p_miso);
        p_mosi   = spi_mosi;
        p_miso   = miso_now;
        old   = m_active;
        new_m = m_mounted;
        na    = old;
        found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (img_mounted[i]) new_m[i] = img_nz[i];
            if (img_mounted[i] && img_nz[i] && !found) begin
                na    = i + 1;
                found = 1'b1;
            end
        end
        if (!found && old != 0 && img_mounted[1'(old - 1)]) begin
            na = 0;
            for (int i = SLOTS - 1; i >= 0; i--) if (new_m[i]) na = i + 1;
        end
        m_mounted = new_m;
        m_active  = na;
        if (img_mounted != 2'b00) last_evt_any = cyc;
        if (na != old) last_evt_chg = cyc;
        pend    = tog;
        pend_ch = m_active;
    endtask

    task automatic check_dut(input string n, input logic [1:0] as, input logic [1:0] mt,
                             input logic ri, input logic [2:0] ac, input logic cs,
                             input logic sck, input logic mo, input logic [1:0] vss,
                             input logic mi, input bit is_chg);
        logic       e_cs;
        logic [1:0] e_vss;
        logic [2:0] e_act;
        int         le;
        e_cs     = spi_ss_n | (m_active != 0);
        e_vss[0] = spi_ss_n | (m_active != 1);
        e_vss[1] = spi_ss_n | (m_active != 2);
        le       = is_chg ? last_evt_chg : last_evt_any;
        for (int c = 0; c < 3; c++) e_act[c] = (cyc - last_clear[c]) < ACT_N;
        chk({n, ".active_slot"}, 32'(as), 32'(m_active));
        chk({n, ".mounted"}, 32'(mt), 32'(m_mounted));
        chk({n, ".reset_img"}, 32'(ri), 32'((cyc - le) < RST_N));
        chk({n, ".act"}, 32'(ac), 32'(e_act));
        chk({n, ".sd_cs_n"}, 32'(cs), 32'(e_cs));
        chk({n, ".sd_sck"}, 32'(sck), 32'(spi_sck & ~e_cs));
        chk({n, ".sd_mosi"}, 32'(mo), 32'(spi_mosi & ~e_cs));
        chk({n, ".vsd_ss_n"}, 32'(vss), 32'(e_vss));
        chk({n, ".spi_miso"}, 32'(mi), 32'(route_miso()));
    endtask

    task automatic check_all();
        check_dut("any", if_any.active_slot, if_any.mounted, if_any.reset_img, if_any.act,
                  if_any.sd_cs_n, if_any.sd_sck, if_any.sd_mosi, if_any.vsd_ss_n,
                  if_any.spi_miso, 1'b0);
        check_dut("chg", if_chg.active_slot, if_chg.mounted, if_chg.reset_img, if_chg.act,
                  if_chg.sd_cs_n, if_chg.sd_sck, if_chg.sd_mosi, if_chg.vsd_ss_n,
                  if_chg.spi_miso, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic mount(input logic [1:0] m, input logic [1:0] nz);
        img_mounted = m;
        img_nz      = nz;
        tick();
        img_mounted = 2'b00;
    endtask

    // Asserts reset between edges, checks the immediate effect, then releases.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async.reset_img", 32'(if_any.reset_img), 32'(0));
        chk("async.act", 32'(if_any.act), 32'(0));
        chk("async.active_slot", 32'(if_any.active_slot), 32'(0));
        check_all();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        img_mounted = 2'b00;
        img_nz      = 2'b00;
        spi_sck     = 1'b0;
        spi_mosi    = 1'b1;
        spi_ss_n    = 1'b1;
        sd_miso     = 1'b1;
        vsd_miso    = 2'b11;
        model_reset();
        #1;
        check_all();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Mount slot1: selection, chip selects and a 16-cycle reset pulse.
        spi_ss_n = 1'b0;
        mount(2'b10, 2'b10);
        chk("s1.active_slot", 32'(if_any.active_slot), 32'(2));
        chk("s1.mounted", 32'(if_any.mounted), 32'(2'b10));
        chk("s1.sd_cs_n", 32'(if_any.sd_cs_n), 32'(1));
        chk("s1.vsd_ss_n", 32'(if_any.vsd_ss_n), 32'(2'b01));
        n = int'(if_any.reset_img);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_any.reset_img) n++;
        end
        chk("s1.rst_len", 32'(n), 32'(RST_N));

        // Mount/unmount sequence with fallback.
        async_reset();
        mount(2'b01, 2'b01);
        chk("s2.after_m0", 32'(if_any.active_slot), 32'(1));
        mount(2'b10, 2'b10);
        chk("s2.after_m1", 32'(if_any.active_slot), 32'(2));
        mount(2'b10, 2'b00);
        chk("s2.after_u1", 32'(if_any.active_slot), 32'(1));
        mount(2'b01, 2'b00);
        chk("s2.after_u0", 32'(if_any.active_slot), 32'(0));

        // Simultaneous mounts, then a retrigger at cycle 10 of the pulse.
        async_reset();
        mount(2'b11, 2'b11);
        chk("s3.active_slot", 32'(if_any.active_slot), 32'(1));
        chk("s3.mounted", 32'(if_any.mounted), 32'(2'b11));
        for (int i = 0; i < 8; i++) tick();
        mount(2'b01, 2'b01);
        n = int'(if_any.reset_img);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_any.reset_img) n++;
        end
        chk("s3.retrig_len", 32'(n), 32'(RST_N));

        // Unmounting an inactive slot leaves the selection-change router quiet.
        mount(2'b10, 2'b00);
        chk("s4.chg.reset_img", 32'(if_chg.reset_img), 32'(0));
        chk("s4.chg.active_slot", 32'(if_chg.active_slot), 32'(1));
        chk("s4.any.reset_img", 32'(if_any.reset_img), 32'(1));
        for (int i = 0; i < 3; i++) tick();

        // One mosi toggle on the physical channel: act=001 for 8 cycles.
        async_reset();
        spi_mosi = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if_any.act == 3'b001) n++;
        end
        chk("s5.act_len", 32'(n), 32'(ACT_N));
        chk("s5.act_end", 32'(if_any.act), 32'(0));

        // Virtual slot1 miso toggle lights only its own channel.
        mount(2'b10, 2'b10);
        for (int i = 0; i < 10; i++) tick();
        vsd_miso = 2'b01;
        tick();
        tick();
        chk("s6.act", 32'(if_any.act), 32'(3'b100));
        vsd_miso = 2'b11;
        tick();

        // Reset mid-pulse with activity running.
        mount(2'b01, 2'b01);
        spi_mosi = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("s7.pre_reset_img", 32'(if_any.reset_img), 32'(1));
        async_reset();

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            img_mounted = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            img_nz      = 2'($urandom);
            spi_sck     = 1'($urandom);
            spi_mosi    = ($urandom_range(0, 3) == 0) ? ~spi_mosi : spi_mosi;
            spi_ss_n    = 1'($urandom);
            sd_miso     = ($urandom_range(0, 3) == 0) ? ~sd_miso : sd_miso;
            vsd_miso    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : vsd_miso;
            tick();
            img_mounted = 2'b00;
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
